// File: rtl/creek_pkg.sv
// Shared types and defaults for the creek instruction store.
package creek_pkg;

  localparam int INSTR_ADDR_WIDTH = 10;
  localparam int INSTR_DATA_WIDTH = 16;

  // Swap handshake states.
  typedef enum logic [2:0] {
    ST_HELD,
    ST_IDLE,
    ST_PAUSE_REQ,
    ST_SWAP,
    ST_RESUME
  } creek_state_e;

  // Handshake timer width; at least one bit so a disabled timeout still
  // gives a valid vector (the timer then only marks the first cycle of a state).
  function automatic int timer_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/creek_dp_ram.sv
// One instruction bank: single write port, single registered read port.
module creek_dp_ram
  import creek_pkg::*;
#(
  parameter int ADDR_WIDTH = INSTR_ADDR_WIDTH,
  parameter int DATA_WIDTH = INSTR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_reg [2**ADDR_WIDTH];

  // Write when enabled; read is registered with no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    rd_data <= mem_reg[rd_addr];
  end

endmodule

// File: rtl/creek_instr_pingpong.sv
// Double-buffered instruction store: host fills the inactive bank while the
// core fetches from the active one; a host swap request runs the
// pause/swap/resume handshake with the core and flips the banks.
module creek_instr_pingpong
  import creek_pkg::*;
#(
  parameter int ADDR_WIDTH     = INSTR_ADDR_WIDTH,
  parameter int DATA_WIDTH     = INSTR_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int START_PAUSED   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] host_address,
  input  logic [DATA_WIDTH-1:0] host_writedata,
  input  logic                  host_write,
  output logic                  host_waitrequest,
  input  logic                  host_swap,
  output logic                  swap_busy,
  output logic                  swap_timeout,
  output logic                  active_bank,
  input  logic [ADDR_WIDTH-1:0] core_instr_address,
  output logic [DATA_WIDTH-1:0] core_instr_data,
  output logic                  core_pause_n,
  output logic                  core_resume,
  input  logic                  core_waiting
);

  localparam int TW = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES) : '1;
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam creek_state_e RESET_STATE = (START_PAUSED != 0) ? ST_HELD : ST_IDLE;

  creek_state_e state_reg, state_next;
  logic [TW-1:0] timer_reg;
  logic          bank_reg, bank_next;
  logic          timeout_reg, timeout_next;
  logic          rd_bank_reg;
  logic          rd_valid_reg;
  logic          timer_expired;
  logic [DATA_WIDTH-1:0] bank_rd_data [2];

  // The timer counts cycles already spent in the state, so expiry fires on
  // the last allowed cycle and the state is left after exactly TIMEOUT_CYCLES.
  assign timer_expired = (TIMEOUT_CYCLES != 0) && (timer_reg >= TIMER_LAST);

  // State, bank, sticky timeout flag and saturating per-state timer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= RESET_STATE;
      bank_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      timer_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      bank_reg    <= bank_next;
      timeout_reg <= timeout_next;
      if (state_next != state_reg) begin
        timer_reg <= '0;
      end else if (timer_reg != TIMER_MAX) begin
        timer_reg <= timer_reg + TW'(1);
      end
    end
  end

  // Handshake next-state logic and Moore outputs.
  always_comb begin
    state_next       = state_reg;
    bank_next        = bank_reg;
    timeout_next     = timeout_reg;
    core_pause_n     = 1'b1;
    core_resume      = 1'b0;
    swap_busy        = 1'b0;
    host_waitrequest = 1'b0;
    case (state_reg)
      ST_HELD: begin
        core_pause_n = 1'b0;
        if (host_swap) begin
          state_next = core_waiting ? ST_SWAP : ST_PAUSE_REQ;
        end
      end
      ST_IDLE: begin
        if (host_swap) begin
          state_next = ST_PAUSE_REQ;
        end
      end
      ST_PAUSE_REQ: begin
        core_pause_n = 1'b0;
        swap_busy    = 1'b1;
        if (core_waiting) begin
          state_next = ST_SWAP;
        end else if (timer_expired) begin
          state_next   = ST_IDLE;
          timeout_next = 1'b1;
        end
      end
      ST_SWAP: begin
        core_pause_n     = 1'b0;
        swap_busy        = 1'b1;
        host_waitrequest = 1'b1;
        bank_next        = ~bank_reg;
        state_next       = ST_RESUME;
      end
      ST_RESUME: begin
        swap_busy   = 1'b1;
        core_resume = (timer_reg == '0);
        if (!core_waiting) begin
          state_next = ST_IDLE;
        end else if (timer_expired) begin
          state_next   = ST_IDLE;
          timeout_next = 1'b1;
        end
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  // Two banks; the host may only write the one the core is not fetching from.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic wr_en;
      assign wr_en = host_write && !host_waitrequest && (bank_reg != 1'(gi));
      creek_dp_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
      ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(host_address),
        .wr_data(host_writedata),
        .rd_addr(core_instr_address),
        .rd_data(bank_rd_data[gi])
      );
    end
  endgenerate

  // Remember which bank each fetch was issued against; blank the output after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_valid_reg <= 1'b0;
      rd_bank_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b1;
      rd_bank_reg  <= bank_reg;
    end
  end

  assign core_instr_data = rd_valid_reg ? bank_rd_data[rd_bank_reg] : '0;
  assign active_bank     = bank_reg;
  assign swap_timeout    = timeout_reg;

endmodule

// File: tb/tb_creek_instr_pingpong.sv
// Self-checking bench for creek_instr_pingpong: directed handshake scenarios
// followed by randomized traffic, all checked against a behavioural model.
`timescale 1ns/1ps
module tb_creek_instr_pingpong;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] host_address = '0;
  logic [DW-1:0] host_writedata = '0;
  logic          host_write = 1'b0;
  logic          host_waitrequest;
  logic          host_swap = 1'b0;
  logic          swap_busy;
  logic          swap_timeout;
  logic          active_bank;
  logic [AW-1:0] core_instr_address = '0;
  logic [DW-1:0] core_instr_data;
  logic          core_pause_n;
  logic          core_resume;
  logic          core_waiting = 1'b0;

  always #5 clk = ~clk;

  creek_instr_pingpong #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .START_PAUSED(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .host_address(host_address), .host_writedata(host_writedata),
    .host_write(host_write), .host_waitrequest(host_waitrequest),
    .host_swap(host_swap), .swap_busy(swap_busy), .swap_timeout(swap_timeout),
    .active_bank(active_bank),
    .core_instr_address(core_instr_address), .core_instr_data(core_instr_data),
    .core_pause_n(core_pause_n), .core_resume(core_resume),
    .core_waiting(core_waiting)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: which phase of a swap we are in and for how long,
  // which bank is live, plus a shadow of both banks' contents.
  int m_phase = 0;   // 0 quiet, 1 waiting for core pause, 2 swapping, 3 waiting for core to run
  int m_age = 0;     // cycles already spent in the current phase
  bit m_held = 1'b1;
  bit m_bank = 1'b0;
  bit m_tmo = 1'b0;
  bit m_rd_valid = 1'b0;
  bit m_rd_known = 1'b0;
  logic [DW-1:0] m_rd_val = '0;
  logic [DW-1:0] m_mem [2][16];
  bit m_known [2][16];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_step();
    if (!reset_n) begin
      m_held = 1'b1; m_phase = 0; m_age = 0; m_bank = 1'b0; m_tmo = 1'b0; m_rd_valid = 1'b0;
    end else begin
      m_rd_valid = 1'b1;
      m_rd_known = m_known[m_bank][core_instr_address];
      m_rd_val   = m_mem[m_bank][core_instr_address];
      if (host_write && m_phase != 2) begin
        m_mem[m_bank ^ 1'b1][host_address]   = host_writedata;
        m_known[m_bank ^ 1'b1][host_address] = 1'b1;
      end
      case (m_phase)
        0: if (host_swap) begin
          m_phase = (m_held && core_waiting) ? 2 : 1;
          m_held = 1'b0; m_age = 0;
          $display("txn swap accepted at %0t (bank %0d live)", $time, m_bank);
        end
        1: if (core_waiting) begin m_phase = 2; m_age = 0; end
           else if (m_age + 1 >= TO) begin m_phase = 0; m_tmo = 1'b1; end
           else m_age++;
        2: begin m_bank ^= 1'b1; m_phase = 3; m_age = 0; end
        3: if (!core_waiting) m_phase = 0;
           else if (m_age + 1 >= TO) begin m_phase = 0; m_tmo = 1'b1; end
           else m_age++;
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pause_n", core_pause_n, !(m_held || m_phase == 1 || m_phase == 2));
      check("busy", swap_busy, m_phase != 0);
      check("resume", core_resume, m_phase == 3 && m_age == 0);
      check("waitreq", host_waitrequest, m_phase == 2);
      check("bank", active_bank, m_bank);
      check("timeout", swap_timeout, m_tmo);
      if (!m_rd_valid) check("fetch_rst", core_instr_data, '0);
      else if (m_rd_known) check("fetch", core_instr_data, m_rd_val);
    end
  end

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_write = 1'b1; host_address = a; host_writedata = d;
    cycle();
    host_write = 1'b0;
    $display("txn write addr %0d data %h", a, d);
  endtask

  task automatic fetch_expect(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_instr_address = a;
    cycle();
    check(name, core_instr_data, d);
    $display("txn fetch addr %0d data %h", a, core_instr_data);
  endtask

  int low_cnt;
  int wr_cnt;
  bit stuck = 1'b0;

  task automatic cyc_count();
    cycle();
    if (!core_pause_n) low_cnt++;
    if (host_waitrequest) wr_cnt++;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 16; a++) begin m_known[b][a] = 1'b0; m_mem[b][a] = '0; end

    // Reset into HELD.
    reset_n = 1'b0;
    cycle(); cycle();
    chk_en = 1'b1;
    check("rst_pause_n", core_pause_n, 0);
    check("rst_bank", active_bank, 0);
    check("rst_busy", swap_busy, 0);
    check("rst_data", core_instr_data, 0);
    reset_n = 1'b1;

    // Load bank 1 while held.
    write_word(4'd5, 32'h0000ABCD);
    write_word(4'd0, 32'h0A0A0A0A);
    write_word(4'd15, 32'hF00DBEEF);
    core_instr_address = 4'd5;
    cycle();
    check("held_bank", active_bank, 0);

    // Swap from HELD with the core already waiting: straight to SWAP.
    core_waiting = 1'b1; host_swap = 1'b1;
    cycle();
    host_swap = 1'b0;
    check("held_swap_wreq", host_waitrequest, 1);
    cycle();
    check("held_swap_bank", active_bank, 1);
    check("held_swap_resume", core_resume, 1);
    cycle();
    check("resume_once", core_resume, 0);
    check("fetch5_new", core_instr_data, 32'h0000ABCD);
    core_waiting = 1'b0;
    cycle();
    check("held_swap_done", swap_busy, 0);
    fetch_expect("fetch0_b1", 4'd0, 32'h0A0A0A0A);
    fetch_expect("fetch15_b1", 4'd15, 32'hF00DBEEF);

    // Fill bank 0, then swap from IDLE with a slow core; same-cycle write goes to bank 0.
    write_word(4'd5, 32'h11111111);
    write_word(4'd0, 32'h00C0FFEE);
    write_word(4'd15, 32'h5A5A5A5A);
    low_cnt = 0; wr_cnt = 0;
    host_swap = 1'b1; host_write = 1'b1; host_address = 4'd3; host_writedata = 32'h33333333;
    cyc_count();
    host_swap = 1'b0; host_write = 1'b0;
    cyc_count(); cyc_count();
    core_waiting = 1'b1;
    cyc_count(); cyc_count(); cyc_count();
    core_waiting = 1'b0;
    cyc_count();
    check("idle_swap_low", low_cnt, 4);
    check("idle_swap_wreq", wr_cnt, 1);
    check("idle_swap_bank", active_bank, 0);
    fetch_expect("fetch3_same_cycle", 4'd3, 32'h33333333);
    fetch_expect("fetch0_b0", 4'd0, 32'h00C0FFEE);
    fetch_expect("fetch15_b0", 4'd15, 32'h5A5A5A5A);
    write_word(4'd5, 32'h77777777);
    fetch_expect("fetch5_live_bank", 4'd5, 32'h11111111);

    // Core never pauses: timeout after TO cycles; a second swap in the window is dropped.
    host_swap = 1'b1;
    cycle();
    for (int i = 0; i < TO - 1; i++) begin
      host_swap = (i == 2);
      cycle();
    end
    host_swap = 1'b0;
    check("tmo_still_busy", swap_busy, 1);
    cycle();
    check("tmo_busy", swap_busy, 0);
    check("tmo_flag", swap_timeout, 1);
    check("tmo_bank", active_bank, 0);
    check("tmo_pause_n", core_pause_n, 1);
    cycle();
    check("tmo_no_queue", swap_busy, 0);

    // Get to bank 1, then reset in the middle of a handshake.
    core_waiting = 1'b1; host_swap = 1'b1;
    cycle();
    host_swap = 1'b0;
    cycle(); cycle();
    core_waiting = 1'b0;
    cycle();
    check("pre_rst_bank", active_bank, 1);
    host_swap = 1'b1;
    cycle();
    host_swap = 1'b0;
    cycle();
    check("mid_busy", swap_busy, 1);
    reset_n = 1'b0;
    cycle();
    check("mid_rst_busy", swap_busy, 0);
    check("mid_rst_bank", active_bank, 0);
    check("mid_rst_tmo", swap_timeout, 0);
    check("mid_rst_held", core_pause_n, 0);
    reset_n = 1'b1;

    // Randomized traffic with a loosely cooperative core model.
    for (int n = 0; n < 4000; n++) begin
      reset_n = ($urandom_range(0, 599) != 0);
      host_write = reset_n ? 1'($urandom_range(0, 1)) : 1'b0;
      host_address = AW'($urandom_range(0, 15));
      host_writedata = $urandom;
      core_instr_address = AW'($urandom_range(0, 15));
      host_swap = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 199) == 0) stuck = !stuck;
      if (!core_pause_n && !core_waiting && !stuck && $urandom_range(0, 2) == 0)
        core_waiting = 1'b1;
      else if (core_pause_n && core_waiting && !stuck && $urandom_range(0, 3) == 0)
        core_waiting = 1'b0;
      cycle();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/creek_instr_pingpong.md
Name: creek_instr_pingpong

Overview:
Double-buffered instruction store for the creek core, generalised in address and data width.
- The host (Nios/Avalon side) loads the inactive bank while the core executes from the active bank.
- A host swap request runs a pause/swap/resume handshake with the core and flips banks without the host touching pause_n or resume.
- Sits between the host instruction-write slave and the core's instruction fetch and control ports; it replaces a single shared instruction RAM.

Parameters:
ADDR_WIDTH, 10, instruction word address width; each bank holds 2^ADDR_WIDTH words
DATA_WIDTH, 16, instruction word width
TIMEOUT_CYCLES, 1024, maximum cycles spent waiting on core_waiting per handshake phase; 0 disables the timeout
START_PAUSED, 1, if 1 the core is held paused after reset until the first swap

Ports:
clk  in  1  single clock
reset_n  in  1  synchronous, active-low reset
host_address  in  ADDR_WIDTH  write address into the inactive bank
host_writedata  in  DATA_WIDTH  write data
host_write  in  1  write strobe
host_waitrequest  out  1  write stall, Avalon semantics
host_swap  in  1  swap request, single-cycle pulse
swap_busy  out  1  high while a swap handshake is in progress
swap_timeout  out  1  sticky handshake-timeout flag
active_bank  out  1  index of the bank the core currently executes from
core_instr_address  in  ADDR_WIDTH  fetch address
core_instr_data  out  DATA_WIDTH  fetch data, registered
core_pause_n  out  1  pause request to the core, active low
core_resume  out  1  one-cycle resume pulse
core_waiting  in  1  core is paused

Behaviour:
- Reset (synchronous, reset_n=0 sampled at a clk edge) sets:
  - state: HELD if START_PAUSED=1, else IDLE
  - active_bank=0, core_resume=0, host_waitrequest=0, swap_busy=0, swap_timeout=0, core_instr_data=0
  - core_pause_n = 0 in HELD, 1 in IDLE
  - RAM contents are not reset.
  - Reset mid-handshake aborts it immediately. There is no partial bank flip.
- Fetch path:
  - Read latency is 1 cycle: address presented at edge t gives data valid after edge t+1.
  - The bank select used is active_bank sampled with the address.
  - The first fetch issued after the SWAP cycle reads the new bank.
- Write path:
  - A write is accepted when host_write=1 and host_waitrequest=0.
  - It writes the bank ~active_bank as it stands in that cycle.
  - host_waitrequest=1 only in the SWAP state, so no write can straddle a bank flip.
- States: HELD, IDLE, PAUSE_REQ, SWAP, RESUME.
  - HELD: core_pause_n=0.
    - host_swap with core_waiting=1 -> SWAP.
    - host_swap with core_waiting=0 -> PAUSE_REQ.
  - IDLE: core_pause_n=1; host_swap -> PAUSE_REQ.
  - PAUSE_REQ: core_pause_n=0, swap_busy=1, timer counts.
    - core_waiting=1 -> SWAP.
    - Timer reaches TIMEOUT_CYCLES -> IDLE with swap_timeout set, core_pause_n=1, no flip.
  - SWAP: lasts exactly 1 cycle; active_bank toggles at its end; -> RESUME.
  - RESUME:
    - core_pause_n=1.
    - core_resume=1 in the first RESUME cycle only.
    - core_waiting=0 -> IDLE.
    - Timeout -> IDLE with swap_timeout set; the bank flip stands.
- Timer:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Clears on every state entry.
  - Saturates; never wraps.
- swap_busy=1 in PAUSE_REQ, SWAP and RESUME.
- host_swap while swap_busy=1 is ignored, not queued.
- host_swap and host_write in the same IDLE cycle: the write goes to the pre-swap inactive bank.
- swap_timeout is cleared only by reset.
- Example latency: host_swap at edge t with core_waiting already high -> core_pause_n low after t+1, SWAP at t+2, active_bank flips at t+3, core_resume high during t+3..t+4.

Decomposition:
- creek_pkg holds:
  - the state enum (HELD, IDLE, PAUSE_REQ, SWAP, RESUME)
  - default width constants INSTR_ADDR_WIDTH=10 and INSTR_DATA_WIDTH=16
- Sub-module creek_dp_ram: one write port, one registered read port, parametrised ADDR_WIDTH/DATA_WIDTH. It is instantiated twice, once per bank.
- The top level holds the FSM, the timer and the bank-select muxing.

Test Plan:
- Reset with START_PAUSED=1 -> core_pause_n=0, active_bank=0, swap_busy=0, core_instr_data=0; write 0xABCD to address 5 -> lands in bank 1, core fetch of address 5 still returns bank-0 contents.
- From HELD, host_swap with core_waiting=1 -> SWAP next cycle, active_bank=1 after it, core_resume high for exactly 1 cycle, fetch address 5 returns 0xABCD one cycle after address issue.
- From IDLE, host_swap, core model raises core_waiting 3 cycles later, drops it 2 cycles after core_resume -> core_pause_n low for 4 cycles, host_waitrequest high only in the SWAP cycle, return to IDLE with active_bank toggled.
- TIMEOUT_CYCLES=8, core_waiting held 0 -> after 8 PAUSE_REQ cycles return to IDLE, swap_timeout=1, active_bank unchanged, core_pause_n=1; a second host_swap during the busy window is ignored.
- Reset asserted in PAUSE_REQ -> next cycle state=HELD, swap_busy=0, active_bank=0, swap_timeout=0.
- ADDR_WIDTH=4, DATA_WIDTH=32: write addresses 0 and 15 and read both back after a swap -> correct values, no aliasing across the bank boundary.
